// File: rtl/qpsk_pkg.sv
// Shared Rx QPSK definitions: symbol record, packing geometry, Tx mapper level and
// the saturating magnitude helper used by the slicer.
package qpsk_pkg;

  localparam int unsigned QPSK_BITS    = 2;
  localparam int unsigned SYM_PER_BYTE = 4;

  // Tx mapper constellation level; the Rx slicer only looks at signs.
  localparam int signed QPSK_LEVEL = 1200;

  typedef struct packed {
    logic [QPSK_BITS-1:0] bits;
    logic                 last;
    logic                 lowm;
  } qpsk_sym_t;

  // |x| for a width-bit two's complement value held sign-extended in 32 bits.
  // The most negative code saturates to the largest positive magnitude.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                          input int unsigned         width);
    logic [31:0] lim;
    logic [31:0] mag;
    lim = (32'd1 << (width - 1)) - 32'd1;
    mag = x[31] ? $unsigned(-x) : $unsigned(x);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/qpsk_demod_if.sv
// Sample-in / byte-out stream bundle of the QPSK demodulator, plus the per-frame
// low-margin report. slave is the demodulator side, master the surrounding fabric.
interface qpsk_demod_if #(
  parameter int unsigned fft_depth = 12,
  parameter int unsigned CNT_W     = 16
);

  logic signed [fft_depth-1:0] in_i;
  logic signed [fft_depth-1:0] in_q;
  logic                        in_last;
  logic                        in_valid;
  logic                        in_ready;
  logic        [fft_depth-2:0] thr;

  logic [7:0]                  out_byte;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  logic [CNT_W-1:0]            lowm_cnt;
  logic                        lowm_valid;

  modport master (
    output in_i, in_q, in_last, in_valid, thr, out_ready,
    input  in_ready, out_byte, out_last, out_valid, lowm_cnt, lowm_valid
  );

  modport slave (
    input  in_i, in_q, in_last, in_valid, thr, out_ready,
    output in_ready, out_byte, out_last, out_valid, lowm_cnt, lowm_valid
  );

endinterface

// File: rtl/qpsk_slicer.sv
// Combinational hard slicer: sign bits to a 2-bit symbol and a low-margin flag
// when the weaker of |I| and |Q| falls below the threshold.
module qpsk_slicer
  import qpsk_pkg::*;
#(
  parameter int unsigned fft_depth = 12
) (
  input  logic signed [fft_depth-1:0] in_i,
  input  logic signed [fft_depth-1:0] in_q,
  input  logic                        in_last,
  input  logic        [fft_depth-2:0] thr,
  output qpsk_sym_t                   sym
);

  logic [31:0] mag_i;
  logic [31:0] mag_q;
  logic [31:0] mag_min;

  always_comb begin
    mag_i   = abs_sat(32'(in_i), fft_depth);
    mag_q   = abs_sat(32'(in_q), fft_depth);
    mag_min = (mag_i < mag_q) ? mag_i : mag_q;

    // Non-negative samples (including zero) slice to 1.
    sym.bits = {~in_q[fft_depth-1], ~in_i[fft_depth-1]};
    sym.last = in_last;
    sym.lowm = (mag_min < 32'(thr));
  end

endmodule

// File: rtl/qpsk_demod.sv
// QPSK Rx demodulator: slice register (S1), 4-slot byte packer (S2), output
// register (S3) on valid/ready, plus a saturating per-frame low-margin counter.
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter int unsigned fft_depth = 12,
  parameter int unsigned CNT_W     = 16
) (
  input logic         clk,
  input logic         rst_n,
  qpsk_demod_if.slave bus
);

  qpsk_sym_t        slice_sym;
  qpsk_sym_t        s1_sym_q;
  logic             s1_valid_q;
  logic [1:0]       k_q;
  logic [7:0]       acc_q;
  logic [7:0]       out_byte_q;
  logic             out_last_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] lowm_cnt_q;
  logic             lowm_valid_q;
  logic             init_q;

  logic             s1_done;
  logic             s3_free;
  logic             s1_stall;
  logic             s1_adv;
  logic             in_fire;
  logic [7:0]       slot_bits;
  logic [7:0]       acc_next;
  logic [CNT_W-1:0] run_next;

  qpsk_slicer #(
    .fft_depth(fft_depth)
  ) u_slicer (
    .in_i   (bus.in_i),
    .in_q   (bus.in_q),
    .in_last(bus.in_last),
    .thr    (bus.thr),
    .sym    (slice_sym)
  );

  always_comb begin
    s1_done  = s1_valid_q && ((k_q == 2'(SYM_PER_BYTE - 1)) || s1_sym_q.last);
    s3_free  = !out_valid_q || bus.out_ready;
    // Only a byte-completing symbol needs room in S3; all others merge into acc.
    s1_stall = s1_done && !s3_free;
    s1_adv   = s1_valid_q && !s1_stall;
    in_fire  = bus.in_valid && bus.in_ready;

    slot_bits = 8'(s1_sym_q.bits) << {k_q, 1'b0};
    acc_next  = acc_q | slot_bits;

    run_next = run_q;
    if (s1_sym_q.lowm && (run_q != '1)) begin
      run_next = run_q + CNT_W'(1);
    end
  end

  // Held low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // S1: sliced symbol register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sym_q   <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_sym_q   <= slice_sym;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: packer, first symbol of a byte lands in the LSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      acc_q <= '0;
    end else if (s1_adv) begin
      if (s1_done) begin
        k_q   <= '0;
        acc_q <= '0;
      end else begin
        k_q   <= k_q + 2'd1;
        acc_q <= acc_next;
      end
    end
  end

  // S3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (s1_adv && s1_done) begin
      out_valid_q <= 1'b1;
      out_byte_q  <= acc_next;
      out_last_q  <= s1_sym_q.last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Low-margin counter: runs per symbol leaving S1, reported and cleared on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= '0;
      lowm_cnt_q   <= '0;
      lowm_valid_q <= 1'b0;
    end else begin
      lowm_valid_q <= 1'b0;
      if (s1_adv) begin
        if (s1_sym_q.last) begin
          lowm_cnt_q   <= run_next;
          lowm_valid_q <= 1'b1;
          run_q        <= '0;
        end else begin
          run_q <= run_next;
        end
      end
    end
  end

  assign bus.in_ready   = init_q && !s1_stall;
  assign bus.out_byte   = out_byte_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.lowm_cnt   = lowm_cnt_q;
  assign bus.lowm_valid = lowm_valid_q;

endmodule

// File: tb/tb_qpsk_demod.sv
// Scoreboard bench for qpsk_demod: directed frames push expected bytes and
// low-margin reports; a negedge monitor pops and compares as the DUT emits them.
module tb_qpsk_demod;
  import qpsk_pkg::*;

  localparam int unsigned FD = 12;
  localparam int unsigned CW = 16;
  localparam int          L  = QPSK_LEVEL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpsk_demod_if #(.fft_depth(FD), .CNT_W(CW)) bus ();

  qpsk_demod #(.fft_depth(FD), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_byte_q[$];  // {last, byte}
  int         exp_lowm_q[$];
  logic [8:0] mon_e;
  int         mon_l;
  bit         saw_stall = 1'b0;
  logic [7:0] m_acc;
  int         m_k;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_byte_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected byte: got 0x%0h last %0d expected none", bus.out_byte,
                 bus.out_last);
      end else begin
        mon_e = exp_byte_q.pop_front();
        chk("out_byte", longint'(bus.out_byte), longint'(mon_e[7:0]));
        chk("out_last", longint'(bus.out_last), longint'(mon_e[8]));
      end
    end
    if (bus.lowm_valid) begin
      if (exp_lowm_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected lowm_valid: got cnt %0d expected none", bus.lowm_cnt);
      end else begin
        mon_l = exp_lowm_q.pop_front();
        chk("lowm_cnt", longint'(bus.lowm_cnt), longint'(mon_l));
      end
    end
    if (rst_n && bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int i, input int q, input bit last, input int th);
    bit ok;
    ok           = 1'b0;
    bus.in_i     = FD'(i);
    bus.in_q     = FD'(q);
    bus.in_last  = last;
    bus.thr      = (FD - 1)'(th);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send timeout: got in_ready 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (exp_byte_q.size() == 0 && exp_lowm_q.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain: got %0d bytes %0d reports pending expected 0 0",
               exp_byte_q.size(), exp_lowm_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Reference packer for the backpressure run.
  task automatic model(input int i, input int q, input bit last);
    logic [7:0] b;
    b     = {6'd0, (q >= 0), (i >= 0)};
    m_acc = m_acc | (b << (2 * m_k));
    if (m_k == 3 || last) begin
      exp_byte_q.push_back({last, m_acc});
      m_acc = '0;
      m_k   = 0;
    end else begin
      m_k++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},   longint'(bus.in_ready),   0);
    chk({tag, " out_valid"},  longint'(bus.out_valid),  0);
    chk({tag, " out_byte"},   longint'(bus.out_byte),   0);
    chk({tag, " out_last"},   longint'(bus.out_last),   0);
    chk({tag, " lowm_cnt"},   longint'(bus.lowm_cnt),   0);
    chk({tag, " lowm_valid"}, longint'(bus.lowm_valid), 0);
  endtask

  initial begin
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.thr       = '0;
    bus.out_ready = 1'b1;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", longint'(bus.in_ready), 1);

    // 1: one symbol per quadrant, latency on the completing symbol.
    exp_byte_q.push_back({1'b1, 8'h1B});
    exp_lowm_q.push_back(0);
    send(L, L, 1'b0, 0);
    send(-L, L, 1'b0, 0);
    send(L, -L, 1'b0, 0);
    send(-L, -L, 1'b1, 0);
    chk("latency out_valid 1 cycle", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("latency out_valid 2 cycles", longint'(bus.out_valid), 1);
    chk("latency out_byte", longint'(bus.out_byte), 8'h1B);
    drain();

    // 2: six (+,+) symbols -> full byte then half-filled last byte.
    exp_byte_q.push_back({1'b0, 8'hFF});
    exp_byte_q.push_back({1'b1, 8'h0F});
    exp_lowm_q.push_back(0);
    for (int n = 0; n < 6; n++) send(L, L, (n == 5), 0);
    drain();

    // 3: zero and most-negative edge samples.
    exp_byte_q.push_back({1'b1, 8'h05});
    exp_lowm_q.push_back(1);
    send(0, -2048, 1'b0, 10);
    send(2047, -2048, 1'b1, 2047);
    drain();

    // 4: 40 symbols under toggling then stalled out_ready.
    m_acc     = '0;
    m_k       = 0;
    saw_stall = 1'b0;
    exp_lowm_q.push_back(0);
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int si;
          int sq;
          si = (n % 2 != 0) ? -500 : 700;
          sq = ((n / 4) % 2 != 0) ? -300 : 900;
          model(si, sq, (n == 39));
          send(si, sq, (n == 39), 0);
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(posedge clk);
          #1;
          bus.out_ready = ~bus.out_ready;
        end
        repeat (20) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'b0;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("in_ready stall seen", longint'(saw_stall), 1);

    // 5: three low-margin symbols, then a clean frame restarting at 0.
    exp_byte_q.push_back({1'b0, 8'hDF});
    exp_byte_q.push_back({1'b1, 8'hCE});
    exp_byte_q.push_back({1'b1, 8'h03});
    exp_lowm_q.push_back(3);
    exp_lowm_q.push_back(0);
    send(L, L, 1'b0, 100);
    send(50, L, 1'b0, 100);
    send(L, -30, 1'b0, 100);
    send(L, L, 1'b0, 100);
    send(-99, 500, 1'b0, 100);
    send(100, 100, 1'b0, 100);
    send(-L, -L, 1'b0, 100);
    send(L, L, 1'b1, 100);
    send(L, L, 1'b1, 100);
    drain();

    // 6: reset mid-frame discards the partial byte.
    send(L, L, 1'b0, 0);
    send(L, L, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midframe reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_byte_q.push_back({1'b1, 8'h00});
    exp_lowm_q.push_back(0);
    for (int n = 0; n < 4; n++) send(-L, -L, (n == 3), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
